// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one execute-stage ALU between the pipeline
// (requester 0) and the auxiliary port (requester 1). Operands are registered onto
// the ALU and held for the op latency; the result returns on a one-cycle strobe.
module alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch,
    output logic             busy
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [3:0] OpMulh = 4'b1011;
    localparam logic [2:0] MulCnt = 3'(MUL_CYCLES);

    state_e     state_q;
    logic [2:0] cnt_q;    // cycles the current op still holds the ALU, counting this one
    logic       ptr_q;    // requester preferred when both are valid
    logic       id_q;     // requester that owns the op in flight

    logic             window;
    logic             win_id;
    logic             handshake;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [3:0]       win_op;
    logic [2:0]       win_cnt;

    // Pick the winner and raise its ready while the ALU can take a new op.
    always_comb begin
        window    = !rst && ((state_q == StIdle) || (cnt_q == 3'd1));
        // A lone requester wins outright; a tie goes to the preferred one.
        win_id    = (&req_valid) ? ptr_q : req_valid[1];
        handshake = window && (|req_valid);
        req_ready = 2'b00;
        if (handshake) begin
            req_ready = win_id ? 2'b10 : 2'b01;
        end
        win_a   = win_id ? req1_a  : req0_a;
        win_b   = win_id ? req1_b  : req0_b;
        win_op  = win_id ? req1_op : req0_op;
        win_cnt = ((win_op == OpMul) || (win_op == OpMulh)) ? MulCnt : 3'd1;
    end

    // Control FSM with registered ALU operands and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'b0000;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (state_q == StBusy) begin
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    // Last hold cycle: the ALU output belongs to the op in flight.
                    rsp_result <= alu_result;
                    rsp_branch <= alu_branch;
                    rsp_valid  <= id_q ? 2'b10 : 2'b01;
                    state_q    <= StIdle;
                    busy       <= 1'b0;
                end
            end
            // A new accept overrides the return to idle so single-cycle ops stream.
            if (handshake) begin
                alu_a   <= win_a;
                alu_b   <= win_b;
                alu_op  <= win_op;
                id_q    <= win_id;
                ptr_q   <= ~win_id;
                cnt_q   <= win_cnt;
                state_q <= StBusy;
                busy    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage `alu` between two requesters: requester 0 is the pipeline execute stage and requester 1 is the auxiliary/accelerator port. The block arbitrates round-robin, registers the winning operands onto the ALU inputs, and holds them stable for the op's latency. MUL/MULH are held for a configurable multi-cycle window. The block then returns the ALU result and branch flag to the winner on a one-cycle response strobe.

## Interface
- `WIDTH`, 32: operand/result width.
- `MUL_CYCLES`, 2: cycles operands are held for MUL (4'b1001) and MULH (4'b1011); legal range 1–4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high per cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_op`  in  4  requester 0 ALU op.
- `req1_a`, `req1_b`  in  WIDTH  requester 1 operands.
- `req1_op`  in  4  requester 1 ALU op.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_op`  out  4  registered op to the ALU.
- `alu_result`  in  WIDTH  ALU result (combinational from `alu_*`).
- `alu_branch`  in  1  ALU branch flag.
- `rsp_valid`  out  2  one-hot response strobe, one cycle wide.
- `rsp_result`  out  WIDTH  captured result, valid while `rsp_valid` != 0.
- `rsp_branch`  out  1  captured branch flag.
- `busy`  out  1  high while an op is in flight.

## Operation
- FSM states:
  - IDLE: no op in flight.
  - BUSY: operands are driven; down-counter `cnt` tracks cycles remaining.
- Accept window:
  - `req_ready` may be high in IDLE, or in BUSY when `cnt`==1 (the last cycle).
  - It is never high during `rst`.
  - A handshake is valid&ready for the same bit.
- Arbitration:
  - With one requester valid, that requester wins.
  - With both valid, the requester not granted last wins.
  - The preference pointer flips to the other requester after every grant.
  - After reset, requester 0 is preferred.
- On a handshake:
  - The winner's a/b/op are latched into `alu_a`/`alu_b`/`alu_op`.
  - The winner id is latched.
  - `cnt` loads `MUL_CYCLES` for ops 1001/1011, else 1.
  - State becomes BUSY.
- In BUSY, `cnt` decrements each cycle. In the cycle with `cnt`==1, `alu_result`/`alu_branch` are captured into `rsp_result`/`rsp_branch` at the edge, and the latched id bit of `rsp_valid` is set for the next cycle. Then:
  - If a new handshake occurs in that same cycle, the block reloads and stays BUSY.
  - Otherwise it goes to IDLE.
- Result and branch flag pass through unmodified for all 16 ops, including branch ops (1100–1111), whose ALU result is all ones.
- Requesters hold valid and operands stable until ready; the arbiter never drops an accepted op.
- `alu_*` hold their last value in IDLE.
- `rsp_result`/`rsp_branch` hold their last value when `rsp_valid`==0.
- There is no response backpressure; a requester must consume its strobe.

## Timing
- Reset values: state IDLE, pointer = requester 0, `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_branch`=0, `alu_a`=0, `alu_b`=0, `alu_op`=4'b0000, `busy`=0.
- Handshake in cycle t → `alu_*` valid cycles t+1 … t+N, where N=1, or N=`MUL_CYCLES` for MUL/MULH → `rsp_valid` high in cycle t+N+1 only.
- Throughput: one single-cycle op per cycle sustained, via back-to-back accept in the last BUSY cycle.
- `busy` = (state==BUSY), registered.
- `rst` asserted mid-op: the op is discarded, no `rsp_valid` is issued, and all outputs take reset values the cycle after the edge.
- `req_ready` is combinational from state, `cnt`, `req_valid` and pointer; there is no combinational path from `alu_result` to any output.

## Test plan
- Add (0000), 5+7 on requester 0 only:
  - `req_ready`=01 in cycle 0.
  - `alu_a`=5, `alu_b`=7 in cycle 1.
  - `rsp_valid`=01, `rsp_result`=12, `rsp_branch`=0 in cycle 2.
- Both valid after reset, req0 add 1+1 and req1 sub (0001) 10−3:
  - req0 accepted cycle 0, req1 accepted cycle 1.
  - `rsp_valid`=01 / result 2 in cycle 2.
  - `rsp_valid`=10 / result 7 in cycle 3.
- MUL, `MUL_CYCLES`=2, a=−3, b=4 → `alu_*` stable cycles 1–2, `req_ready`=00 in cycle 1, `rsp_result`=0xFFFFFFF4 in cycle 3. Repeat with MULH → 0xFFFFFFFF.
- Both requesters held valid for 8 adds → grants strictly alternate 0,1,0,1,…, with no idle cycle between responses.
- BEQ (1100), a=b=0x1234 → `rsp_branch`=1, `rsp_result`=0xFFFFFFFF. BNE (1101) on the same operands → `rsp_branch`=0.
- `rst` asserted in cycle 1 of a 2-cycle MUL → no `rsp_valid` ever appears. All outputs are at reset values in cycle 2, and req0 is preferred on the next simultaneous request.
